// File: rtl/mult_ctrl_ph_pkg.sv
// mult_ctrl_ph_pkg -- shared types and constants for the shift-add multiplier
// controller.
//   DEF_WIDTH : default operand width
//   state_t   : controller FSM states
//   cnt_w()   : width of the iteration counter for a given operand width
package mult_ctrl_ph_pkg;

  localparam int DEF_WIDTH = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_ADD,
    S_SHIFT,
    S_DONE
  } state_t;

  // The counter must be able to hold WIDTH.
  function automatic int cnt_w(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/mult_ctrl_ph_if.sv
// mult_ctrl_ph_if -- bus between the multiplier controller and its user, which
// also owns the low-product shift register.
//   start/mcand/mplier : multiply request
//   busy/done/qph      : status and high half of the product
//   load/sft/ph_low/dpl: strobes and data into the low-product register
//   qpl0               : LSB of the low-product register, fed back
// master = requester / low register owner, slave = controller.
interface mult_ctrl_ph_if #(
  parameter int WIDTH = mult_ctrl_ph_pkg::DEF_WIDTH
);
  logic             start;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic             qpl0;
  logic             load;
  logic             sft;
  logic             ph_low;
  logic [WIDTH-1:0] dpl;
  logic [WIDTH-1:0] qph;
  logic             busy;
  logic             done;

  modport master (
    output start, mcand, mplier, qpl0,
    input  load, sft, ph_low, dpl, qph, busy, done
  );

  modport slave (
    input  start, mcand, mplier, qpl0,
    output load, sft, ph_low, dpl, qph, busy, done
  );
endinterface

// File: rtl/mult_ctrl_ph_add.sv
// mult_ph_add -- conditional adder for one shift-add step.
//   a   : running high partial product
//   b   : multiplicand
//   en  : add b when set (current multiplier bit)
//   sum : WIDTH+1-bit result, MSB is the carry out
module mult_ph_add #(
  parameter int WIDTH = mult_ctrl_ph_pkg::DEF_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             en,
  output logic [WIDTH:0]   sum
);
  assign sum = {1'b0, a} + (en ? {1'b0, b} : '0);
endmodule

// File: rtl/mult_ctrl_ph.sv
// mult_ctrl_ph -- shift-add multiplier controller. Holds the high half of the
// product; the low half lives in an external shift register loaded with the
// multiplier and shifted right once per iteration, its LSB returned on qpl0.
// Ports:
//   clk   : clock, rising edge
//   clr_n : synchronous active-low reset
//   bus   : mult_ctrl_ph_if.slave (request, status, low-register control)
// Build option:
//   MULT_FAST_ADD_SHIFT_EN : add and shift in one state, WIDTH+3 cycles per
//   multiply instead of 2*WIDTH+3.
module mult_ctrl_ph
  import mult_ctrl_ph_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic            clk,
  input  logic            clr_n,
  mult_ctrl_ph_if.slave   bus
);
  localparam int CW = cnt_w(WIDTH);

  state_t           st, st_nxt;
  logic [WIDTH-1:0] mcand_r, mplier_r, qph_r;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic [WIDTH:0]   sum;
  logic             last;
  logic             load_c, sft_c, ph_low_c, done_c;

  mult_ph_add #(.WIDTH(WIDTH)) u_add (
    .a   (qph_r),
    .b   (mcand_r),
    .en  (bus.qpl0),
    .sum (sum)
  );

  // Counter value during the final iteration's shifting state.
  assign last = (cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (!clr_n) st <= S_IDLE;
    else        st <= st_nxt;
  end

  always_comb begin
    st_nxt   = st;
    load_c   = 1'b0;
    sft_c    = 1'b0;
    ph_low_c = 1'b0;
    done_c   = 1'b0;
    case (st)
      S_IDLE: if (bus.start) st_nxt = S_LOAD;
      S_LOAD: begin
        load_c = 1'b1;
        st_nxt = S_ADD;
      end
`ifdef MULT_FAST_ADD_SHIFT_EN
      // Merged step: the bit leaving the sum LSB goes straight into the
      // low register, so the add result never needs to be registered whole.
      S_ADD: begin
        sft_c    = 1'b1;
        ph_low_c = sum[0];
        if (last) st_nxt = S_DONE;
      end
`else
      S_ADD: st_nxt = S_SHIFT;
      S_SHIFT: begin
        sft_c    = 1'b1;
        ph_low_c = qph_r[0];
        st_nxt   = last ? S_DONE : S_ADD;
      end
`endif
      S_DONE: begin
        done_c = 1'b1;
        st_nxt = S_IDLE;
      end
      default: st_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!clr_n) begin
      mcand_r  <= '0;
      mplier_r <= '0;
      qph_r    <= '0;
      carry    <= 1'b0;
      cnt      <= '0;
    end else begin
      case (st)
        S_IDLE: if (bus.start) begin
          mcand_r  <= bus.mcand;
          mplier_r <= bus.mplier;
          qph_r    <= '0;
          carry    <= 1'b0;
        end
        S_LOAD: cnt <= '0;
`ifdef MULT_FAST_ADD_SHIFT_EN
        S_ADD: begin
          {carry, qph_r} <= {1'b0, sum[WIDTH:1]};
          cnt            <= cnt + 1'b1;
        end
`else
        S_ADD: {carry, qph_r} <= sum;
        // Carry re-enters at the top of the high half.
        S_SHIFT: begin
          {carry, qph_r} <= {1'b0, carry, qph_r[WIDTH-1:1]};
          cnt            <= cnt + 1'b1;
        end
`endif
        default: ;
      endcase
    end
  end

  assign bus.load   = load_c;
  assign bus.sft    = sft_c;
  assign bus.ph_low = ph_low_c;
  assign bus.done   = done_c;
  assign bus.busy   = (st != S_IDLE);
  assign bus.dpl    = mplier_r;
  assign bus.qph    = qph_r;

endmodule
